div_seq: RTL and testbench

- Iterative radix-2 restoring divider controller for DIV/DIVU in the EX stage of the 5-stage MIPS pipeline.
- Accepts one divide request, sequences WIDTH subtract-shift steps, and holds the pipeline through the stall bus until {remainder, quotient} is ready for HI/LO write-back.
- Supports cancel on pipeline flush.

---
 rtl/div_seq_pkg.sv | 16 +
 rtl/div_seq_if.sv | 21 ++
 rtl/div_step.sv | 19 +
 rtl/div_seq.sv | 120 ++++++++++++
 tb/tb_div_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and encodings for the sequential MIPS DIV/DIVU unit.
package div_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DBZ  = 2'b01,
    S_ON   = 2'b10,
    S_END  = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider request/response bundle, including the stall request.
interface div_seq_if #(parameter int WIDTH = 32);
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               cancel;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               stallreq;

  modport master (
    output div_start, div_signed, opdata1, opdata2, cancel,
    input  result, ready, stallreq
  );

  modport slave (
    input  div_start, div_signed, opdata1, opdata2, cancel,
    output result, ready, stallreq
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] trial;

  // rem_i < dsr_i always holds, so the top bit of the W+1-bit trial is its sign
  always_comb begin
    trial = {rem_i, dvd_msb_i} - {1'b0, dsr_i};
    q_o   = ~trial[WIDTH];
    rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], dvd_msb_i};
  end
endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU; stalls EX until {rem, quot} is ready.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave dif
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   step_rem, quot_fix, rem_fix, a_mag, b_mag;
  logic               step_q;

  // dq_q holds the dividend and shifts quotient bits in from the LSB;
  // after WIDTH steps it contains the unsigned quotient.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dq_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign a_mag    = (dif.div_signed && dif.opdata1[WIDTH-1]) ? -dif.opdata1 : dif.opdata1;
  assign b_mag    = (dif.div_signed && dif.opdata2[WIDTH-1]) ? -dif.opdata2 : dif.opdata2;
  assign quot_fix = neg_q_q ? -{dq_q[WIDTH-2:0], step_q} : {dq_q[WIDTH-2:0], step_q};
  assign rem_fix  = neg_r_q ? -step_rem : step_rem;

  assign dif.stallreq = (state_q == S_IDLE && dif.div_start && !dif.cancel) ||
                        state_q == S_ON || state_q == S_DBZ;
  assign dif.result   = result_q;
  assign dif.ready    = ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (dif.div_start == DIV_START && !dif.cancel) begin
          dq_d    = a_mag;
          dsr_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = dif.div_signed & (dif.opdata1[WIDTH-1] ^ dif.opdata2[WIDTH-1]);
          neg_r_d = dif.div_signed & dif.opdata1[WIDTH-1];
          state_d = (dif.opdata2 == '0) ? S_DBZ : S_ON;
        end
      end
      S_ON: begin
        if (dif.cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          dq_d  = {dq_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d  = S_END;
            result_d = {rem_fix, quot_fix};
          end
        end
      end
      S_DBZ: begin
        if (dif.cancel) begin
          state_d = S_IDLE;
        end else begin
          result_d = '0;
          state_d  = S_END;
        end
      end
      S_END: begin
        if (dif.cancel || dif.div_start == DIV_STOP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Random + directed bench for div_seq: driver pushes expected results, monitor pops on ready.
module tb_div_seq;
  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) dif ();

  div_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic rdy_prev = 1'b0;
  logic [2*W-1:0] last_result = '0;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, rem sign = dividend sign.
  function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] qq, rr;
    if (b == 0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qq = q;
      rr = r;
      return {rr[W-1:0], qq[W-1:0]};
    end
    return {a % b, a / b};
  endfunction

  // Monitor: every rising ready must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dif.ready && !rdy_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", dif.result, e.res);
        chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
      end
    end
    rdy_prev <= dif.ready;
  end

  task automatic do_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int hold);
    exp_t e;
    int n = 0, nstall = 0, lat;
    lat = (b == 0) ? 2 : W + 1;
    @(negedge clk);
    dif.div_start  = 1'b1;
    dif.div_signed = s;
    dif.opdata1    = a;
    dif.opdata2    = b;
    start_cyc      = cyc;
    e.res = exp;
    e.lat = lat;
    sb_q.push_back(e);
    forever begin
      #1;
      if (dif.ready || n >= 100) break;
      if (dif.stallreq) nstall++;
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 64'd1, 64'd0);
    chk("stall_cycles", 64'(nstall), 64'(lat));
    chk("stall_in_end", {63'd0, dif.stallreq}, 64'd0);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", {63'd0, dif.ready}, 64'd1);
      chk("hold_result", dif.result, exp);
    end
    dif.div_start = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, dif.ready}, 64'd0);
    last_result = exp;
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit s;
    dif.div_start  = 1'b0;
    dif.div_signed = 1'b0;
    dif.opdata1    = '0;
    dif.opdata2    = '0;
    dif.cancel     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", dif.result, '0);
    chk("rst_ready", {63'd0, dif.ready}, 64'd0);
    chk("rst_stall", {63'd0, dif.stallreq}, 64'd0);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    do_div(1'b1, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    do_div(1'b1, 32'd7, -32'sd2, 64'h00000001_FFFFFFFD, 0);
    do_div(1'b0, 32'd5, 32'd0, 64'h0, 0);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 5);

    // Cancel at cycle 10: no result, state back to idle, result register untouched.
    @(negedge clk);
    dif.div_start = 1'b1; dif.div_signed = 1'b0;
    dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3;
    repeat (10) @(negedge clk);
    dif.cancel = 1'b1; dif.div_start = 1'b0;
    @(negedge clk);
    dif.cancel = 1'b0;
    chk("cancel_ready", {63'd0, dif.ready}, 64'd0);
    chk("cancel_stall", {63'd0, dif.stallreq}, 64'd0);
    chk("cancel_result", dif.result, last_result);
    repeat (40) @(negedge clk);
    chk("cancel_result_late", dif.result, last_result);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);

    // Reset at cycle 20 of a divide.
    @(negedge clk);
    dif.div_start = 1'b1; dif.div_signed = 1'b1;
    dif.opdata1 = 32'hDEADBEEF; dif.opdata2 = 32'd17;
    repeat (20) @(negedge clk);
    rst = 1'b1; dif.div_start = 1'b0;
    @(negedge clk);
    chk("midrst_result", dif.result, '0);
    chk("midrst_ready", {63'd0, dif.ready}, 64'd0);
    chk("midrst_stall", {63'd0, dif.stallreq}, 64'd0);
    rst = 1'b0;
    last_result = '0;

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: b = -W'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      if (i == 7) begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
      do_div(s, a, b, model(s, a, b), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
